// File: rtl/peridot_avm_arbiter.sv
// Two-requester Avalon-MM arbiter onto one shared master port.
// It tracks outstanding reads so that read data always returns to the requester that issued it.
module peridot_avm_arbiter #(
  parameter int    MAX_PENDING = 4,
  parameter string FAIR_SWITCH = "ON"
) (
  input  logic        csi_avmclock_clk,
  input  logic        csi_avmclock_reset,
  input  logic [31:0] avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [3:0]  avs_s0_byteenable,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  output logic        avs_s0_readdatavalid,
  input  logic [31:0] avs_s1_address,
  input  logic        avs_s1_read,
  input  logic        avs_s1_write,
  input  logic [3:0]  avs_s1_byteenable,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  output logic        avs_s1_waitrequest,
  output logic        avs_s1_readdatavalid,
  output logic [31:0] avm_m1_address,
  output logic        avm_m1_read,
  output logic        avm_m1_write,
  output logic [3:0]  avm_m1_byteenable,
  output logic [31:0] avm_m1_writedata,
  input  logic [31:0] avm_m1_readdata,
  input  logic        avm_m1_waitrequest,
  input  logic        avm_m1_readdatavalid,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  localparam logic [3:0] MAXP = 4'(MAX_PENDING);
  localparam bit         FAIR = (FAIR_SWITCH == "ON");

  state_t     state_q;
  logic       owner_q, last_grant_q;
  logic [3:0] pending_q;

  logic req0, req1, own_req, oth_req, own_rd, own_wr;
  logic in_grant, pend_nz, pend_full;
  logic rd_ok, wr_ok, acc, acc_rd, rdv, own_wait, grant_nxt;

  assign req0      = avs_s0_read | avs_s0_write;
  assign req1      = avs_s1_read | avs_s1_write;
  assign own_req   = owner_q ? req1 : req0;
  assign oth_req   = owner_q ? req0 : req1;
  assign own_rd    = owner_q ? avs_s1_read  : avs_s0_read;
  assign own_wr    = owner_q ? avs_s1_write : avs_s0_write;
  assign in_grant  = (state_q == GRANT);
  assign pend_nz   = (pending_q != 4'd0);
  assign pend_full = (pending_q >= MAXP);

  // Reads stall once the outstanding window is full; writes are never throttled.
  assign rd_ok  = in_grant & own_rd & ~pend_full;
  assign wr_ok  = in_grant & own_wr;
  assign acc    = (rd_ok | wr_ok) & ~avm_m1_waitrequest;
  assign acc_rd = rd_ok & ~avm_m1_waitrequest;
  assign rdv    = avm_m1_readdatavalid & pend_nz;

  assign own_wait = in_grant ? (avm_m1_waitrequest | (own_rd & pend_full)) : 1'b1;

  assign avm_m1_address    = owner_q ? avs_s1_address    : avs_s0_address;
  assign avm_m1_byteenable = owner_q ? avs_s1_byteenable : avs_s0_byteenable;
  assign avm_m1_writedata  = owner_q ? avs_s1_writedata  : avs_s0_writedata;
  assign avm_m1_read       = rd_ok;
  assign avm_m1_write      = wr_ok;

  assign avs_s0_readdata      = avm_m1_readdata;
  assign avs_s1_readdata      = avm_m1_readdata;
  assign avs_s0_waitrequest   = owner_q ? 1'b1 : own_wait;
  assign avs_s1_waitrequest   = owner_q ? own_wait : 1'b1;
  assign avs_s0_readdatavalid = rdv & ~owner_q;
  assign avs_s1_readdatavalid = rdv &  owner_q;

  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

  // On contention, alternate away from whoever won last.
  assign grant_nxt = (req0 & req1) ? ~last_grant_q : req1;

  always_ff @(posedge csi_avmclock_clk or posedge csi_avmclock_reset) begin
    if (csi_avmclock_reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pending_q    <= 4'd0;
    end else begin
      if (acc_rd && !rdv)      pending_q <= pending_q + 4'd1;
      else if (!acc_rd && rdv) pending_q <= pending_q - 4'd1;

      case (state_q)
        IDLE: if (req0 || req1) begin
          state_q      <= GRANT;
          owner_q      <= grant_nxt;
          last_grant_q <= grant_nxt;
        end
        GRANT: begin
          if (!own_req)                    state_q <= pend_nz ? DRAIN : IDLE;
          else if (FAIR && acc && oth_req) state_q <= DRAIN;
        end
        DRAIN: if (!pend_nz || (pending_q == 4'd1 && rdv)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peridot_avm_arbiter.sv
// Directed bench for peridot_avm_arbiter: a fair-switching instance and a non-switching instance share stimulus.
module tb_peridot_avm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] s0_addr, s0_wd, s1_addr, s1_wd;
  logic        s0_rd, s0_wr, s1_rd, s1_wr;
  logic [3:0]  s0_be, s1_be;
  logic [31:0] m_rdata;
  logic        m_wait, m_rdv;

  logic [31:0] a_s0_rdata, a_s1_rdata, a_m_addr, a_m_wd;
  logic        a_s0_wait, a_s0_rdv, a_s1_wait, a_s1_rdv, a_m_rd, a_m_wr, a_owner, a_busy;
  logic [3:0]  a_m_be;
  logic [31:0] b_s0_rdata, b_s1_rdata, b_m_addr, b_m_wd;
  logic        b_s0_wait, b_s0_rdv, b_s1_wait, b_s1_rdv, b_m_rd, b_m_wr, b_owner, b_busy;
  logic [3:0]  b_m_be;

  int checks = 0;
  int failures = 0;

  peridot_avm_arbiter #(.MAX_PENDING(4), .FAIR_SWITCH("ON")) dut_a (
    .csi_avmclock_clk(clk), .csi_avmclock_reset(rst),
    .avs_s0_address(s0_addr), .avs_s0_read(s0_rd), .avs_s0_write(s0_wr),
    .avs_s0_byteenable(s0_be), .avs_s0_writedata(s0_wd),
    .avs_s0_readdata(a_s0_rdata), .avs_s0_waitrequest(a_s0_wait), .avs_s0_readdatavalid(a_s0_rdv),
    .avs_s1_address(s1_addr), .avs_s1_read(s1_rd), .avs_s1_write(s1_wr),
    .avs_s1_byteenable(s1_be), .avs_s1_writedata(s1_wd),
    .avs_s1_readdata(a_s1_rdata), .avs_s1_waitrequest(a_s1_wait), .avs_s1_readdatavalid(a_s1_rdv),
    .avm_m1_address(a_m_addr), .avm_m1_read(a_m_rd), .avm_m1_write(a_m_wr),
    .avm_m1_byteenable(a_m_be), .avm_m1_writedata(a_m_wd),
    .avm_m1_readdata(m_rdata), .avm_m1_waitrequest(m_wait), .avm_m1_readdatavalid(m_rdv),
    .owner(a_owner), .busy(a_busy)
  );

  peridot_avm_arbiter #(.MAX_PENDING(4), .FAIR_SWITCH("OFF")) dut_b (
    .csi_avmclock_clk(clk), .csi_avmclock_reset(rst),
    .avs_s0_address(s0_addr), .avs_s0_read(s0_rd), .avs_s0_write(s0_wr),
    .avs_s0_byteenable(s0_be), .avs_s0_writedata(s0_wd),
    .avs_s0_readdata(b_s0_rdata), .avs_s0_waitrequest(b_s0_wait), .avs_s0_readdatavalid(b_s0_rdv),
    .avs_s1_address(s1_addr), .avs_s1_read(s1_rd), .avs_s1_write(s1_wr),
    .avs_s1_byteenable(s1_be), .avs_s1_writedata(s1_wd),
    .avs_s1_readdata(b_s1_rdata), .avs_s1_waitrequest(b_s1_wait), .avs_s1_readdatavalid(b_s1_rdv),
    .avm_m1_address(b_m_addr), .avm_m1_read(b_m_rd), .avm_m1_write(b_m_wr),
    .avm_m1_byteenable(b_m_be), .avm_m1_writedata(b_m_wd),
    .avm_m1_readdata(m_rdata), .avm_m1_waitrequest(m_wait), .avm_m1_readdatavalid(m_rdv),
    .owner(b_owner), .busy(b_busy)
  );

  task automatic clk1;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    s0_addr = '0; s0_rd = 0; s0_wr = 0; s0_be = 4'hF; s0_wd = '0;
    s1_addr = '0; s1_rd = 0; s1_wr = 0; s1_be = 4'hF; s1_wd = '0;
    m_rdata = '0; m_wait = 0; m_rdv = 0;
  endtask

  task automatic do_reset;
    rst = 1; idle_inputs();
    clk1(); clk1();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs();
    clk1(); clk1();
    checks++; if (a_busy !== 1'b0 || a_owner !== 1'b0) begin failures++; $display("FAIL reset_busy_owner got=%b%b exp=00", a_busy, a_owner); end
    checks++; if (a_m_rd !== 1'b0 || a_m_wr !== 1'b0) begin failures++; $display("FAIL reset_avm_cmd got rd=%b wr=%b exp=0/0", a_m_rd, a_m_wr); end
    checks++; if (a_s0_wait !== 1'b1 || a_s1_wait !== 1'b1) begin failures++; $display("FAIL reset_waitreq got=%b%b exp=11", a_s0_wait, a_s1_wait); end
    checks++; if (a_s0_rdv !== 1'b0 || a_s1_rdv !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b%b exp=00", a_s0_rdv, a_s1_rdv); end
    checks++; if (dut_a.pending_q !== 4'd0 || dut_a.last_grant_q !== 1'b1) begin failures++; $display("FAIL reset_regs got pend=%0d lg=%b exp=0/1", dut_a.pending_q, dut_a.last_grant_q); end
    rst = 0;
    clk1();
  endtask

  task automatic test_arbitration;
    do_reset();
    s0_addr = 32'h100; s1_addr = 32'h200; s0_be = 4'h3; s0_rd = 1; s1_rd = 1;
    #1;
    checks++; if (a_s0_wait !== 1'b1 || a_s1_wait !== 1'b1 || a_m_rd !== 1'b0) begin failures++; $display("FAIL arb_latency got w=%b%b rd=%b exp=11/0", a_s0_wait, a_s1_wait, a_m_rd); end
    clk1();
    checks++; if (a_owner !== 1'b0 || a_m_rd !== 1'b1 || a_m_addr !== 32'h100 || a_m_be !== 4'h3) begin failures++; $display("FAIL arb_grant0 got own=%b rd=%b addr=%h be=%h", a_owner, a_m_rd, a_m_addr, a_m_be); end
    checks++; if (a_s0_wait !== 1'b0 || a_s1_wait !== 1'b1) begin failures++; $display("FAIL arb_grant0_wait got=%b%b exp=01", a_s0_wait, a_s1_wait); end
    clk1();
    s0_rd = 0; m_rdata = 32'hDEAD_BEEF; m_rdv = 1;
    #1;
    checks++; if (a_busy !== 1'b1 || a_m_rd !== 1'b0 || a_s0_wait !== 1'b1 || a_s1_wait !== 1'b1) begin failures++; $display("FAIL arb_drain got busy=%b rd=%b w=%b%b", a_busy, a_m_rd, a_s0_wait, a_s1_wait); end
    checks++; if (a_s0_rdv !== 1'b1 || a_s1_rdv !== 1'b0 || a_s0_rdata !== 32'hDEAD_BEEF || a_s1_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL arb_return got rdv=%b%b d0=%h d1=%h", a_s0_rdv, a_s1_rdv, a_s0_rdata, a_s1_rdata); end
    clk1();
    m_rdv = 0;
    checks++; if (a_busy !== 1'b0 || dut_a.pending_q !== 4'd0) begin failures++; $display("FAIL arb_idle got busy=%b pend=%0d exp=0/0", a_busy, dut_a.pending_q); end
    clk1();
    checks++; if (a_owner !== 1'b1 || a_m_addr !== 32'h200 || a_s1_wait !== 1'b0 || a_s0_wait !== 1'b1) begin failures++; $display("FAIL arb_grant1 got own=%b addr=%h w=%b%b", a_owner, a_m_addr, a_s0_wait, a_s1_wait); end
  endtask

  task automatic test_max_pending;
    int issued, returned, acc_before;
    bit seen_ret, full_seen;
    int rq[$];
    do_reset();
    issued = 0; returned = 0; acc_before = 0; seen_ret = 0; full_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++; if (dut_a.pending_q !== 4'(issued - returned)) begin failures++; $display("FAIL maxp_pending cyc=%0d got=%0d exp=%0d", cyc, dut_a.pending_q, issued - returned); end
      m_rdv   = (rq.size() > 0 && rq[0] == cyc);
      m_rdata = 32'hA000 + 32'(returned);
      s0_rd   = (issued < 6);
      s0_addr = 32'(issued);
      #1;
      if (s0_rd && (issued - returned) == 4) begin
        full_seen = 1;
        checks++; if (a_m_rd !== 1'b0 || a_s0_wait !== 1'b1) begin failures++; $display("FAIL maxp_stall cyc=%0d got rd=%b w=%b exp=0/1", cyc, a_m_rd, a_s0_wait); end
      end
      if (m_rdv) begin
        checks++; if (a_s0_rdv !== 1'b1 || a_s0_rdata !== 32'hA000 + 32'(returned)) begin failures++; $display("FAIL maxp_return cyc=%0d got rdv=%b d=%h", cyc, a_s0_rdv, a_s0_rdata); end
        void'(rq.pop_front());
        returned++; seen_ret = 1;
      end
      if (a_m_rd && !m_wait) begin
        rq.push_back(cyc + 8);
        issued++;
        if (!seen_ret) acc_before++;
      end
      clk1();
    end
    m_rdv = 0; s0_rd = 0;
    checks++; if (acc_before != 4) begin failures++; $display("FAIL maxp_before_return got=%0d exp=4", acc_before); end
    checks++; if (issued != 6 || returned != 6 || !full_seen) begin failures++; $display("FAIL maxp_totals got iss=%0d ret=%0d full=%b exp=6/6/1", issued, returned, full_seen); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL maxp_end_busy got=%b exp=0", a_busy); end
  endtask

  task automatic test_same_cycle;
    do_reset();
    s0_rd = 1;
    clk1(); clk1(); clk1();
    checks++; if (dut_a.pending_q !== 4'd2) begin failures++; $display("FAIL same_pre got=%0d exp=2", dut_a.pending_q); end
    m_rdv = 1;
    #1;
    checks++; if (a_m_rd !== 1'b1 || a_s0_rdv !== 1'b1) begin failures++; $display("FAIL same_both got rd=%b rdv=%b exp=1/1", a_m_rd, a_s0_rdv); end
    clk1();
    checks++; if (dut_a.pending_q !== 4'd2) begin failures++; $display("FAIL same_hold got=%0d exp=2", dut_a.pending_q); end
    m_rdv = 0; s0_rd = 0;
  endtask

  task automatic test_spurious;
    do_reset();
    m_rdv = 1; m_rdata = 32'h1234_5678;
    #1;
    checks++; if (a_s0_rdv !== 1'b0 || a_s1_rdv !== 1'b0 || b_s0_rdv !== 1'b0 || b_s1_rdv !== 1'b0) begin failures++; $display("FAIL spur_rdv got=%b%b%b%b exp=0000", a_s0_rdv, a_s1_rdv, b_s0_rdv, b_s1_rdv); end
    clk1();
    checks++; if (dut_a.pending_q !== 4'd0 || a_busy !== 1'b0) begin failures++; $display("FAIL spur_state got pend=%0d busy=%b exp=0/0", dut_a.pending_q, a_busy); end
    m_rdv = 0;
  endtask

  task automatic test_fair_off;
    int wcnt;
    bit switched;
    do_reset();
    wcnt = 0; switched = 0;
    s1_wd = 32'hFFFF_0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s0_wr = (wcnt < 10); s0_wd = 32'hC000 + 32'(wcnt); s1_wr = 1;
      #1;
      if (cyc == 4) begin
        checks++; if (a_owner !== 1'b1 || a_busy !== 1'b1) begin failures++; $display("FAIL fair_on_switch got own=%b busy=%b exp=1/1", a_owner, a_busy); end
      end
      if (b_owner === 1'b1 && b_busy === 1'b1) begin
        switched = 1;
        checks++; if (wcnt != 10 || b_s1_wait !== 1'b0 || b_m_wd !== 32'hFFFF_0000) begin failures++; $display("FAIL fair_off_switch got wcnt=%0d w1=%b wd=%h exp=10/0/ffff0000", wcnt, b_s1_wait, b_m_wd); end
        break;
      end
      if (b_m_wr && !m_wait) begin
        checks++; if (b_owner !== 1'b0 || b_m_wd !== 32'hC000 + 32'(wcnt)) begin failures++; $display("FAIL fair_off_word got own=%b wd=%h exp=0/%h", b_owner, b_m_wd, 32'hC000 + 32'(wcnt)); end
        wcnt++;
      end
      clk1();
    end
    checks++; if (!switched) begin failures++; $display("FAIL fair_off_timeout got switched=0 exp=1 wcnt=%0d", wcnt); end
    s0_wr = 0; s1_wr = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    s0_rd = 1;
    clk1(); clk1(); clk1(); clk1();
    s0_rd = 0;
    checks++; if (dut_a.pending_q !== 4'd3 || a_busy !== 1'b1) begin failures++; $display("FAIL rmid_pre got pend=%0d busy=%b exp=3/1", dut_a.pending_q, a_busy); end
    rst = 1;
    #1;
    checks++; if (a_busy !== 1'b0 || dut_a.pending_q !== 4'd0 || a_s0_wait !== 1'b1 || a_s1_wait !== 1'b1 || a_m_rd !== 1'b0) begin failures++; $display("FAIL rmid_async got busy=%b pend=%0d w=%b%b rd=%b", a_busy, dut_a.pending_q, a_s0_wait, a_s1_wait, a_m_rd); end
    clk1();
    checks++; if (a_busy !== 1'b0 || dut_a.pending_q !== 4'd0 || a_owner !== 1'b0) begin failures++; $display("FAIL rmid_clk got busy=%b pend=%0d own=%b", a_busy, dut_a.pending_q, a_owner); end
    rst = 0; m_rdv = 1;
    #1;
    checks++; if (a_s0_rdv !== 1'b0 || a_s1_rdv !== 1'b0) begin failures++; $display("FAIL rmid_late_rdv got=%b%b exp=00", a_s0_rdv, a_s1_rdv); end
    clk1();
    checks++; if (dut_a.pending_q !== 4'd0) begin failures++; $display("FAIL rmid_late_pend got=%0d exp=0", dut_a.pending_q); end
    m_rdv = 0;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_max_pending();
    test_same_cycle();
    test_spurious();
    test_fair_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peridot_avm_arbiter.md
PERIDOT_AVM_ARBITER -- requirements
Module: peridot_avm_arbiter

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4, maximum outstanding reads on the shared port (1..15).
REQ-002 SHALL have parameter FAIR_SWITCH, default "ON"; "ON" yields the port after every accepted command when the other requester waits, "OFF" yields only when the owner drops its request.
REQ-003 csi_avmclock_clk  in  1  sole clock; all logic on rising edge.
REQ-004 csi_avmclock_reset  in  1  asynchronous, active-high reset.
REQ-005 avs_s0_address/read/write/byteenable/writedata  in  32/1/1/4/32  requester 0 command.
REQ-006 avs_s0_readdata/waitrequest/readdatavalid  out  32/1/1  requester 0 response.
REQ-007 avs_s1_* identical set for requester 1.
REQ-008 avm_m1_address/read/write/byteenable/writedata  out  32/1/1/4/32  shared master command.
REQ-009 avm_m1_readdata/waitrequest/readdatavalid  in  32/1/1  shared master response.
REQ-010 owner  out  1  current grant index; busy  out  1  high when state is not IDLE.

Function
REQ-011 States SHALL be IDLE, GRANT, DRAIN; owner register selects requester in GRANT/DRAIN.
REQ-012 Request of requester n SHALL be avs_sn_read OR avs_sn_write.
REQ-013 IDLE: if any request, next state GRANT with owner = requester not equal to last_grant when both request, else the single requester; last_grant updated to new owner.
REQ-014 IDLE: both avs waitrequest SHALL be 1 and avm_m1_read/write SHALL be 0; grant takes effect the cycle after request (1-cycle arbitration latency).
REQ-015 GRANT: avm command outputs SHALL combinationally mirror owner inputs; owner waitrequest = avm_m1_waitrequest; non-owner waitrequest = 1.
REQ-016 GRANT with pending == MAX_PENDING: avm_m1_read SHALL be forced 0 and owner waitrequest forced 1 for read commands; writes still pass.
REQ-017 Accepted command = avm_m1_read or write high with avm_m1_waitrequest low.
REQ-018 pending counter (4 bits) SHALL increment on accepted read, decrement on avm_m1_readdatavalid, hold when both occur same cycle.
REQ-019 avm_m1_readdatavalid with pending == 0 SHALL be ignored (no counter change, no valid routed).
REQ-020 avs_s0_readdata and avs_s1_readdata SHALL both equal avm_m1_readdata; avs_sn_readdatavalid = avm_m1_readdatavalid AND pending != 0 AND owner == n.
REQ-021 GRANT -> DRAIN when FAIR_SWITCH="ON", accepted command, other requester requesting; or owner request low and pending != 0.
REQ-022 GRANT -> IDLE when owner request low and pending == 0.
REQ-023 DRAIN: avm_m1_read/write SHALL be 0, both waitrequest 1; readdatavalid still routed to owner.
REQ-024 DRAIN -> IDLE when pending == 0, or pending == 1 and readdatavalid this cycle.
REQ-025 Owner SHALL never change while pending != 0.

Reset
REQ-026 On reset: state IDLE, pending 0, owner 0, last_grant 1, busy 0, avm_m1_read/write 0, both waitrequest 1, both readdatavalid 0.
REQ-027 Reset mid-transaction SHALL discard pending count; readdatavalid after reset release with pending 0 is ignored per REQ-019.

Verification
REQ-028 Both requesters read simultaneously from reset, zero-latency slave -> requester 0 granted cycle 2, one read accepted, then DRAIN, data returned, requester 1 granted next.
REQ-029 Requester 0 issues 6 back-to-back reads, readdatavalid delayed 8 cycles, MAX_PENDING=4 -> exactly 4 avm_m1_read acceptances before first return, pending never exceeds 4.
REQ-030 Accepted read and readdatavalid same cycle at pending=2 -> pending stays 2.
REQ-031 Spurious avm_m1_readdatavalid in IDLE -> both avs readdatavalid remain 0, pending 0.
REQ-032 FAIR_SWITCH="OFF", requester 0 writes 10 words while requester 1 waits -> all 10 complete before owner switches to 1.
REQ-033 Assert reset with pending=3 -> next cycle state IDLE, pending 0, waitrequests 1.
